pb_event_queue: RTL and testbench

//  Input stage upstream of simonstate. Conditions the raw keypad pb[15:0]:
//   2-FF sync, whole-vector debounce, press-edge detect, encode to 4-bit key code.

---
 rtl/simon_pkg.sv | 14 +
 rtl/pb_debounce.sv | 70 +++++++
 rtl/pb_event_queue.sv | 124 ++++++++++++
 tb/tb_pb_event_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared key-event types for the Simon keypad path.
// pb_event_queue produces key_event_t; simonstate and the display consume them.
package simon_pkg;

  localparam int NKEYS = 16;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic      multi;  // more than one key was held when this press registered
    key_code_t code;   // index of the newly pressed key
  } key_event_t;

endpackage

// File: rtl/pb_debounce.sv
// Keypad conditioner: 2-FF synchronizer followed by a whole-vector debounce.
// Ports:
//   clk, rst   clock, async active-low reset
//   pb_i       raw asynchronous buttons
//   cand_o     vector currently being qualified
//   db_o       last accepted (debounced) vector
//   accept_o   one-cycle strobe: db takes cand on this edge
//   rise_o     keys newly pressed by that accept (cand & ~db)
module pb_debounce #(
  parameter int NKEYS    = 16,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] pb_i,
  output logic [NKEYS-1:0] cand_o,
  output logic [NKEYS-1:0] db_o,
  output logic             accept_o,
  output logic [NKEYS-1:0] rise_o
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [NKEYS-1:0] s1_q, s2_q;
  logic [NKEYS-1:0] cand_q, cand_d;
  logic [NKEYS-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // Any change of the synchronized vector restarts qualification; the vector
  // must then hold for DEBOUNCE further edges before it replaces db.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    accept = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (db_q != cand_q) begin
      db_d   = cand_q;
      accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else begin
      s1_q   <= pb_i;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign cand_o   = cand_q;
  assign db_o     = db_q;
  assign accept_o = accept;
  assign rise_o   = cand_q & ~db_q;

endmodule

// File: rtl/pb_event_queue.sv
// Keypad front end for simonstate: debounced press edges are encoded to a
// key code and queued so presses made while the consumer is busy survive.
// Ports:
//   clk, rst   100 Hz clock, async active-low reset
//   pb         raw pushbuttons
//   pop        consumer takes the head event this cycle (ignored when empty)
//   clear      synchronous flush of queue and overflow flag
//   valid      queue non-empty
//   code       head key index (0 when empty)
//   multi      head event had >1 key held (0 when empty)
//   count      entries held
//   overflow   sticky: a press was dropped because the queue was full
module pb_event_queue #(
  parameter int NKEYS    = 16,
  parameter int DEBOUNCE = 2,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS-1:0]         pb,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     valid,
  output logic [3:0]               code,
  output logic                     multi,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  import simon_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [NKEYS-1:0] cand, db, rise;
  logic             accept;

  pb_debounce #(.NKEYS(NKEYS), .DEBOUNCE(DEBOUNCE)) u_db (
    .clk      (clk),
    .rst      (rst),
    .pb_i     (pb),
    .cand_o   (cand),
    .db_o     (db),
    .accept_o (accept),
    .rise_o   (rise)
  );

  // Encoder: lowest newly-pressed key wins, so simultaneous rises collapse
  // into a single event.
  key_event_t ev;
  always_comb begin
    ev.code = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (rise[i]) ev.code = i[3:0];
    end
    // x & (x-1) clears the lowest set bit; non-zero means two or more held.
    ev.multi = |(cand & (cand - 1'b1));
  end

  // FIFO
  key_event_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            push_req, do_push, do_pop, full, wr_en;

  assign valid    = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign push_req = accept & (|rise);
  assign do_pop   = pop & valid;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push  = push_req & (~full | do_pop);
  assign wr_en    = do_push & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req & full & ~do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: it is only observed through valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ev;
  end

  key_event_t head;
  assign head     = mem_q[rd_ptr_q];
  assign code     = valid ? head.code  : 4'd0;
  assign multi    = valid ? head.multi : 1'b0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pb_event_queue.sv
module tb_pb_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pb;
  logic        pop;
  logic        clear;
  logic        valid;
  logic [3:0]  code;
  logic        multi;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  pb_event_queue #(.NKEYS(16), .DEBOUNCE(2), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .pop      (pop),
    .clear    (clear),
    .valid    (valid),
    .code     (code),
    .multi    (multi),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      $error("%s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  // Isolated press: push lands on the 6th edge; 8 edges each side is ample.
  task automatic press(input int k);
    pb = 16'(1) << k;
    tick(8);
    pb = '0;
    tick(8);
  endtask

  initial begin
    int keys5 [5];
    int exp_codes [4];
    keys5     = '{1, 4, 7, 10, 13};
    exp_codes = '{4, 7, 10, 15};

    // 1: reset with key 5 held
    rst = 1'b0; pb = 16'h0020; pop = 1'b0; clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_valid", 32'(valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_code",  32'(code), 0);
      check("rst_ovf",   32'(overflow), 0);
    end
    rst = 1'b1;
    tick(5);
    check("t1_count_e5", 32'(count), 0);
    tick(1);
    check("t1_valid_e6", 32'(valid), 1);
    check("t1_code", 32'(code), 5);
    check("t1_multi", 32'(multi), 0);
    check("t1_count", 32'(count), 1);
    pb = '0;
    do_pop();
    check("t1_count_pop", 32'(count), 0);
    tick(8);
    check("t1_release", 32'(count), 0);

    // 2: key 5 held 10 cycles
    pb = 16'h0020;
    tick(5);
    check("t2_valid_e5", 32'(valid), 0);
    tick(1);
    check("t2_valid_e6", 32'(valid), 1);
    check("t2_code", 32'(code), 5);
    check("t2_multi", 32'(multi), 0);
    tick(4);
    pb = '0;
    tick(10);
    check("t2_count_rel", 32'(count), 1);
    do_pop();
    check("t2_count_pop", 32'(count), 0);
    check("t2_valid_pop", 32'(valid), 0);
    check("t2_code_empty", 32'(code), 0);
    tick(8);
    check("t2_no_more", 32'(count), 0);

    // 3: bounce on key 3
    pb = 16'h0008; tick(1); check("t3_b0", 32'(count), 0);
    pb = 16'h0000; tick(1); check("t3_b1", 32'(count), 0);
    pb = 16'h0008; tick(1); check("t3_b2", 32'(count), 0);
    pb = 16'h0000; tick(1); check("t3_b3", 32'(count), 0);
    pb = 16'h0008;
    tick(5);
    check("t3_count_e5", 32'(count), 0);
    tick(1);
    check("t3_count", 32'(count), 1);
    check("t3_code", 32'(code), 3);
    check("t3_multi", 32'(multi), 0);
    pb = '0;
    tick(8);
    check("t3_single", 32'(count), 1);
    do_pop();
    check("t3_pop", 32'(count), 0);

    // 4: simultaneous keys 2 and 9, then add 12
    pb = 16'h0204;
    tick(6);
    check("t4_count", 32'(count), 1);
    check("t4_code", 32'(code), 2);
    check("t4_multi", 32'(multi), 1);
    do_pop();
    check("t4_pop", 32'(count), 0);
    pb = 16'h1204;
    tick(5);
    check("t4_count_e5", 32'(count), 0);
    tick(1);
    check("t4b_count", 32'(count), 1);
    check("t4b_code", 32'(code), 12);
    check("t4b_multi", 32'(multi), 1);
    pb = '0;
    tick(8);
    do_pop();
    check("t4_end", 32'(count), 0);

    // 5: overflow with DEPTH=4
    for (int i = 0; i < 5; i++) begin
      press(keys5[i]);
      check("t5_fill", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    check("t5_ovf", 32'(overflow), 1);
    check("t5_head", 32'(code), 1);
    pb = 16'h8000;
    tick(5);
    check("t5_pre", 32'(count), 4);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    check("t5_pushpop_cnt", 32'(count), 4);
    check("t5_pushpop_ovf", 32'(overflow), 1);
    pb = '0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      check("t5_order", 32'(code), 32'(exp_codes[i]));
      do_pop();
      check("t5_drain", 32'(count), 32'(3 - i));
    end

    // 6: clear races a push
    press(6);
    press(8);
    check("t6_count2", 32'(count), 2);
    check("t6_head", 32'(code), 6);
    pb = 16'h0800;
    tick(5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t6_clr_count", 32'(count), 0);
    check("t6_clr_ovf", 32'(overflow), 0);
    check("t6_clr_valid", 32'(valid), 0);
    tick(8);
    check("t6_lost", 32'(count), 0);
    do_pop();
    check("t6_empty_pop", 32'(count), 0);
    check("t6_empty_valid", 32'(valid), 0);
    check("t6_empty_code", 32'(code), 0);
    pb = '0;
    tick(8);
    check("t6_end", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
